// File: rtl/prog_clock_divider.sv
// Programmable integer clock divider (N >= 2) with a glitch-free enable and a
// req/ack ratio update that takes effect only on a period boundary.
module prog_clock_divider #(
    parameter int CNT_W     = 26,
    parameter int DIV_RESET = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div_i,
    input  logic             upd_req,
    output logic             upd_ack,
    output logic             clk_out,
    output logic             tick,
    output logic             running
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] ZERO_C    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] TWO_C     = {{(CNT_W-2){1'b0}}, 2'b10};
    localparam logic [CNT_W-1:0] DIV_RST_C = CNT_W'(DIV_RESET);

    // Ratios below 2 cannot form a high and a low phase, so they clamp to 2.
    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
        if (d < TWO_C) begin
            clamp_div = TWO_C;
        end else begin
            clamp_div = d;
        end
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] cur_div_r;
    logic [CNT_W-1:0] cur_div_nxt_s;
    logic [CNT_W-1:0] pend_div_r;
    logic [CNT_W-1:0] pend_div_nxt_s;
    logic             pend_vld_r;
    logic             pend_vld_nxt_s;
    logic             clk_out_r;
    logic             clk_out_nxt_s;
    logic             tick_r;
    logic             tick_nxt_s;
    logic             upd_ack_r;
    logic             upd_ack_nxt_s;
    logic             running_r;
    logic             running_nxt_s;

    logic             boundary_s;
    logic             apply_s;
    logic             upd_vld_s;
    logic [CNT_W-1:0] upd_div_s;

    // A request arriving on the apply edge bypasses the pending register.
    assign boundary_s = (state_r == RUN) && (cnt_r == (cur_div_r - ONE_C));
    assign apply_s    = (state_r == IDLE) || boundary_s;
    assign upd_vld_s  = upd_req || pend_vld_r;
    assign upd_div_s  = upd_req ? clamp_div(div_i) : pend_div_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: RUN is left only at a period boundary.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (en) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (boundary_s && !en) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Ratio update path: capture, overwrite, or apply at the boundary.
    always_comb begin
        cur_div_nxt_s  = cur_div_r;
        pend_div_nxt_s = pend_div_r;
        pend_vld_nxt_s = pend_vld_r;
        upd_ack_nxt_s  = 1'b0;
        if (apply_s && upd_vld_s) begin
            cur_div_nxt_s  = upd_div_s;
            pend_vld_nxt_s = 1'b0;
            upd_ack_nxt_s  = 1'b1;
        end else if (upd_req) begin
            pend_div_nxt_s = clamp_div(div_i);
            pend_vld_nxt_s = 1'b1;
        end else begin
            pend_vld_nxt_s = pend_vld_r;
        end
    end

    // Output logic: next counter and registered clk_out/tick/running values.
    always_comb begin
        cnt_nxt_s     = ZERO_C;
        clk_out_nxt_s = 1'b0;
        tick_nxt_s    = 1'b0;
        running_nxt_s = (state_nxt_s == RUN);
        case (state_r)
            RUN: begin
                if (!boundary_s) begin
                    cnt_nxt_s     = cnt_r + ONE_C;
                    clk_out_nxt_s = (cnt_nxt_s < (cur_div_r >> 1));
                end else if (en) begin
                    clk_out_nxt_s = 1'b1;
                    tick_nxt_s    = 1'b1;
                end else begin
                    clk_out_nxt_s = 1'b0;
                end
            end
            IDLE: begin
                if (en) begin
                    clk_out_nxt_s = 1'b1;
                    tick_nxt_s    = 1'b1;
                end else begin
                    clk_out_nxt_s = 1'b0;
                end
            end
            default: begin
                cnt_nxt_s = ZERO_C;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r      <= ZERO_C;
            cur_div_r  <= DIV_RST_C;
            pend_div_r <= DIV_RST_C;
            pend_vld_r <= 1'b0;
            clk_out_r  <= 1'b0;
            tick_r     <= 1'b0;
            upd_ack_r  <= 1'b0;
            running_r  <= 1'b0;
        end else begin
            cnt_r      <= cnt_nxt_s;
            cur_div_r  <= cur_div_nxt_s;
            pend_div_r <= pend_div_nxt_s;
            pend_vld_r <= pend_vld_nxt_s;
            clk_out_r  <= clk_out_nxt_s;
            tick_r     <= tick_nxt_s;
            upd_ack_r  <= upd_ack_nxt_s;
            running_r  <= running_nxt_s;
        end
    end

    assign clk_out = clk_out_r;
    assign tick    = tick_r;
    assign upd_ack = upd_ack_r;
    assign running = running_r;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider: expected per-cycle outputs are queued
// as periods are scheduled and popped/compared one clk cycle at a time.
module tb_prog_clock_divider;

    localparam int CNT_W = 26;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [CNT_W-1:0] div_i;
    logic             upd_req;
    logic             upd_ack;
    logic             clk_out;
    logic             tick;
    logic             running;

    typedef struct {
        logic [3:0] v;   // {clk_out, tick, running, upd_ack}
        string      tag;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    prog_clock_divider #(.CNT_W(CNT_W), .DIV_RESET(1024)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .div_i   (div_i),
        .upd_req (upd_req),
        .upd_ack (upd_ack),
        .clk_out (clk_out),
        .tick    (tick),
        .running (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic c, input logic t, input logic r, input logic a, input string tag);
        exp_t e;
        e.v   = {c, t, r, a};
        e.tag = tag;
        q.push_back(e);
    endtask

    // One full period of ratio n: high floor(n/2) cycles, tick on the first.
    task automatic push_period(input int n, input bit ack_first, input string tag);
        for (int i = 0; i < n; i++) begin
            push(i < (n / 2), i == 0, 1'b1, ack_first && (i == 0), tag);
        end
    endtask

    task automatic push_idle(input int k, input bit ack_first, input string tag);
        for (int i = 0; i < k; i++) begin
            push(1'b0, 1'b0, 1'b0, ack_first && (i == 0), tag);
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        n_tests++;
        if (q.size() == 0) begin
            n_fail++;
            $error("FAIL queue_empty observed=%b expected=<none>", {clk_out, tick, running, upd_ack});
        end else begin
            e = q.pop_front();
            assert ({clk_out, tick, running, upd_ack} === e.v) else begin
                n_fail++;
                $error("FAIL %s observed=%b expected=%b", e.tag, {clk_out, tick, running, upd_ack}, e.v);
            end
        end
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic check_now(input string tag, input logic [3:0] exp_v);
        n_tests++;
        assert ({clk_out, tick, running, upd_ack} === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, {clk_out, tick, running, upd_ack}, exp_v);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        div_i   = '0;
        upd_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_now("reset", 4'b0000);

        // Default ratio 1024 straight out of reset.
        rst_n = 1'b1;
        en    = 1'b1;
        push_period(1024, 1'b0, "p1024_a");
        steps(1024);

        // Mid-period request for 5: current 1024 period completes first.
        push_period(1024, 1'b0, "p1024_b");
        steps(100);
        upd_req = 1'b1; div_i = 26'd5;
        step();
        upd_req = 1'b0;
        steps(1024 - 101);
        push_period(5, 1'b1, "n5_first");
        push_period(5, 1'b0, "n5");
        steps(10);

        // div_i = 0 clamps to 2.
        push_period(5, 1'b0, "n5_c");
        steps(2);
        upd_req = 1'b1; div_i = 26'd0;
        step();
        upd_req = 1'b0;
        steps(2);
        push_period(2, 1'b1, "div0_first");
        push_period(2, 1'b0, "div0");
        steps(4);

        // div_i = 1 clamps to 2.
        push_period(2, 1'b0, "div0_b");
        step();
        upd_req = 1'b1; div_i = 26'd1;
        step();
        upd_req = 1'b0;
        push_period(2, 1'b1, "div1_first");
        push_period(2, 1'b0, "div1");
        steps(4);

        // Request coincident with the boundary edge applies immediately.
        push_period(2, 1'b0, "n2_byp");
        steps(2);
        upd_req = 1'b1; div_i = 26'd7;
        push_period(7, 1'b1, "byp7_first");
        step();
        upd_req = 1'b0;
        steps(6);

        // Stop at cnt=2: the period still completes, then idle, then restart.
        push_period(7, 1'b0, "n7_stop");
        steps(3);
        en = 1'b0;
        steps(4);
        push_idle(3, 1'b0, "idle");
        steps(3);
        en = 1'b1;
        push_period(7, 1'b0, "n7_restart");
        steps(7);

        // Two requests in one period: latest wins, single ack.
        push_period(7, 1'b0, "n7_2req");
        step();
        upd_req = 1'b1; div_i = 26'd6;
        step();
        div_i = 26'd9;
        step();
        upd_req = 1'b0;
        steps(4);
        push_period(9, 1'b1, "n9_first");
        push_period(9, 1'b0, "n9");
        steps(18);

        // en and upd_req together in IDLE: first period uses the new ratio.
        push_period(9, 1'b0, "n9_stop");
        step();
        en = 1'b0;
        steps(8);
        push_idle(2, 1'b0, "idle9");
        steps(2);
        en = 1'b1; upd_req = 1'b1; div_i = 26'd3;
        push_period(3, 1'b1, "idle_req3");
        step();
        upd_req = 1'b0;
        steps(2);

        // Stop and pending update at the same boundary: ack while going idle.
        push_period(3, 1'b0, "n3_sp");
        step();
        upd_req = 1'b1; div_i = 26'd4; en = 1'b0;
        step();
        upd_req = 1'b0;
        step();
        push_idle(1, 1'b1, "stop_ack");
        push_idle(1, 1'b0, "stop_idle");
        steps(2);
        en = 1'b1;
        push_period(4, 1'b0, "n4");
        steps(4);

        // Reset at cnt=3 of N=10, then back to the default ratio.
        push_period(4, 1'b0, "n4_b");
        step();
        upd_req = 1'b1; div_i = 26'd10;
        step();
        upd_req = 1'b0;
        steps(2);
        push_period(10, 1'b1, "n10");
        steps(4);
        rst_n = 1'b0;
        #1;
        check_now("rst_mid", 4'b0000);
        q.delete();
        @(posedge clk);
        #1;
        check_now("rst_hold", 4'b0000);
        rst_n = 1'b1;
        push_period(1024, 1'b0, "post_rst");
        steps(1024);

        n_tests++;
        assert (q.size() === 0) else begin
            n_fail++;
            $error("FAIL queue_drain observed=%0d expected=0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
